alu_out_buffer: RTL and testbench
=================================

# alu_out_buffer

Result buffer sitting directly downstream of the ALU DUT in the ALU verification environment. It captures every valid ALU result (EX_ALU qualified by EX_ALU_VLD) into a circular FIFO and presents the results to the output monitor/scoreboard side over a ready/valid handshake. The ALU has no backpressure input, so results arriving while the buffer is full are dropped and counted, and a sticky overflow flag is raised.

## Interface
- DATA_WIDTH, 8, width of one ALU result; must match the ALU's DATA_WIDTH.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16, width of the drop counter.

- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- EX_ALU  in  DATA_WIDTH  ALU result.
- EX_ALU_VLD  in  1  EX_ALU valid this cycle.
- OUT_DATA  out  DATA_WIDTH  head-of-FIFO result; meaningful only while OUT_VLD=1.
- OUT_VLD  out  1  head entry available.
- OUT_RDY  in  1  consumer accepts the head entry.
- LEVEL  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- FULL  out  1  LEVEL==DEPTH.
- EMPTY  out  1  LEVEL==0.
- DROP_CNT  out  CNT_WIDTH  number of dropped results, saturating.
- OVERFLOW  out  1  sticky; set on the first drop.
- CLR_CNT  in  1  synchronous clear of DROP_CNT and OVERFLOW.

## Operation
- Storage: DEPTH x DATA_WIDTH array, write pointer and read pointer, each $clog2(DEPTH)+1 bits. The MSB is the wrap bit. EMPTY when the pointers are equal. FULL when the low bits are equal and the MSBs differ.
- pop = OUT_VLD & OUT_RDY. On pop, the read pointer increments modulo 2*DEPTH.
- push = EX_ALU_VLD & (!FULL | pop). On push, EX_ALU is written at the write pointer and the write pointer increments modulo 2*DEPTH.
  - When FULL, a push in the same cycle as a pop is accepted, and LEVEL stays at DEPTH.
- drop = EX_ALU_VLD & FULL & !pop. The result is discarded.
  - DROP_CNT increments and saturates at all-ones.
  - OVERFLOW is set to 1.
- CLR_CNT=1 forces DROP_CNT to 0 and OVERFLOW to 0 at the edge. Clear has priority over a drop in the same cycle; that drop is not counted.
- LEVEL next value:
  - +1 on push without pop.
  - -1 on pop without push.
  - Unchanged otherwise.
- Pop while EMPTY is impossible, because OUT_VLD=0.
- Push and pop in the same cycle while EMPTY: only the push occurs.
- Results leave in arrival order. No reordering and no duplication.
- Reset (RST=0, at any time, including mid-transfer) takes effect immediately, independent of CLK:
  - Pointers, LEVEL, DROP_CNT and OVERFLOW go to 0.
  - The storage array goes to 0.
  - Outputs: OUT_VLD=0, OUT_DATA=0, LEVEL=0, FULL=0, EMPTY=1, DROP_CNT=0, OVERFLOW=0.
  - Contents buffered before reset are lost.
  - The first capture happens at the first rising edge with RST=1.

## Timing
- OUT_DATA = mem[read pointer] (first-word fall-through). OUT_VLD = !EMPTY.
- Latency: a result pushed at edge k gives OUT_VLD=1 with that data right after edge k, when the buffer was empty before the push.
- A pop at edge k exposes the next entry right after edge k. With OUT_RDY held at 1, the buffer sustains 1 result per cycle.
- OUT_DATA and OUT_VLD do not depend combinationally on OUT_RDY.
- FULL, EMPTY, LEVEL, DROP_CNT and OVERFLOW are registered, or derived only from registered pointers. They update at the same edge as the push, pop or drop that causes the change.
- OUT_DATA is held stable while OUT_VLD=1 and OUT_RDY=0.

## Test plan
Parameters for all scenarios: DATA_WIDTH=8, DEPTH=4.
- Reset check: assert RST=0 mid-stream while LEVEL=3 and no CLK edge occurs -> all outputs at their reset values immediately, EMPTY=1. After release, the first push of 0x11 appears on OUT_DATA with OUT_VLD=1.
- Ordering: push 0x01, 0x02, 0x03 on consecutive cycles with OUT_RDY=0, then set OUT_RDY=1 -> pops return 0x01, 0x02, 0x03 on consecutive cycles, then EMPTY=1 and LEVEL=0.
- Full and drop: push 0xA0..0xA5 with OUT_RDY=0 -> FULL=1 after the 4th push, DROP_CNT=2, OVERFLOW=1. Draining returns 0xA0..0xA3 only.
- Full with simultaneous pop: at FULL, push 0xB4 with OUT_RDY=1 -> no drop, LEVEL stays 4. 0xB4 is the last entry popped.
- Wrap-around: 10 push/pop pairs with values 0..9 at level 1 -> outputs 0..9 in order, pointers wrap twice, DROP_CNT=0.
- Counter clear: with DROP_CNT=3, assert CLR_CNT together with a drop -> DROP_CNT=0 and OVERFLOW=0. The next drop gives DROP_CNT=1 and OVERFLOW=1.

Source files
------------

// File: rtl/alu_out_buffer.sv
// Result buffer behind the ALU: a first-word-fall-through circular FIFO
// that drops and counts results arriving while full, since the ALU cannot stall.
module alu_out_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   EX_ALU,
  input  logic                    EX_ALU_VLD,
  output logic [DATA_WIDTH-1:0]   OUT_DATA,
  output logic                    OUT_VLD,
  input  logic                    OUT_RDY,
  output logic [$clog2(DEPTH):0]  LEVEL,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [CNT_WIDTH-1:0]    DROP_CNT,
  output logic                    OVERFLOW,
  input  logic                    CLR_CNT
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic                  overflow_q, overflow_d;

  logic empty, full, pop, push, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop frees a slot in the same edge, so a full buffer still accepts a result then.
  assign pop  = !empty && OUT_RDY;
  assign push = EX_ALU_VLD && (!full || pop);
  assign drop = EX_ALU_VLD && full && !pop;

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned, which would infer a latch.
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = EX_ALU;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    // Clear wins over a coincident drop; that drop is not counted.
    if (CLR_CNT) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      // NOTE: the storage is reset too, so OUT_DATA reads 0 out of reset rather than stale contents.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign OUT_DATA = mem_q[rd_ptr_q[AW-1:0]];
  assign OUT_VLD  = !empty;
  assign LEVEL    = level_q;
  assign FULL     = full;
  assign EMPTY    = empty;
  assign DROP_CNT = drop_cnt_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_alu_out_buffer.sv
// Self-checking bench for alu_out_buffer: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_alu_out_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] ex_alu;
  logic          ex_alu_vld;
  logic [DW-1:0] out_data;
  logic          out_vld;
  logic          out_rdy;
  logic [2:0]    level;
  logic          full;
  logic          empty;
  logic [CW-1:0] drop_cnt;
  logic          overflow;
  logic          clr_cnt;

  always #5 clk = ~clk;

  alu_out_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .CLK(clk), .RST(rst_n), .EX_ALU(ex_alu), .EX_ALU_VLD(ex_alu_vld),
    .OUT_DATA(out_data), .OUT_VLD(out_vld), .OUT_RDY(out_rdy),
    .LEVEL(level), .FULL(full), .EMPTY(empty),
    .DROP_CNT(drop_cnt), .OVERFLOW(overflow), .CLR_CNT(clr_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: an ordered queue of accepted results plus drop bookkeeping.
  logic [DW-1:0] mq[$];
  int            m_drop;
  bit            m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input bit vld, input logic [DW-1:0] d, input bit rdy, input bit clr);
    bit is_full, do_pop, do_push, do_drop;
    is_full = (mq.size() == DEPTH);
    do_pop  = (mq.size() > 0) && rdy;
    do_push = vld && (!is_full || do_pop);
    do_drop = vld && is_full && !do_pop;
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(d);
    if (clr) begin
      m_drop = 0;
      m_ovf  = 1'b0;
    end else if (do_drop) begin
      if (m_drop != 65535) m_drop++;
      m_ovf = 1'b1;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".vld"},   32'(out_vld),  32'(mq.size() != 0));
    check({tag, ".level"}, 32'(level),    32'(mq.size()));
    check({tag, ".full"},  32'(full),     32'(mq.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty),    32'(mq.size() == 0));
    check({tag, ".drop"},  32'(drop_cnt), 32'(m_drop));
    check({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) check({tag, ".data"}, 32'(out_data), 32'(mq[0]));
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare #1 after the edge.
  task automatic cycle(input bit vld, input logic [DW-1:0] d, input bit rdy, input bit clr, input string tag);
    ex_alu_vld = vld;
    ex_alu     = d;
    out_rdy    = rdy;
    clr_cnt    = clr;
    model_step(vld, d, rdy, clr);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic idle_inputs();
    ex_alu_vld = 1'b0;
    ex_alu     = '0;
    out_rdy    = 1'b0;
    clr_cnt    = 1'b0;
  endtask

  typedef struct {
    logic          vld;
    logic [DW-1:0] data;
    logic          rdy;
    logic [2:0]    e_level;
    logic          e_vld;
    logic [DW-1:0] e_data;
    logic          e_full;
    logic [CW-1:0] e_drop;
    logic          e_ovf;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [DW-1:0] data, input logic rdy,
                              input logic [2:0] lv, input logic ov, input logic [DW-1:0] od,
                              input logic fu, input logic [CW-1:0] dc, input logic of);
    vec_t v;
    v.vld = vld; v.data = data; v.rdy = rdy;
    v.e_level = lv; v.e_vld = ov; v.e_data = od; v.e_full = fu; v.e_drop = dc; v.e_ovf = of;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    // Ordering: three pushes, then three pops.
    tbl[0]  = mk(1'b1, 8'h01, 1'b0, 3'd1, 1'b1, 8'h01, 1'b0, 16'd0, 1'b0);
    tbl[1]  = mk(1'b1, 8'h02, 1'b0, 3'd2, 1'b1, 8'h01, 1'b0, 16'd0, 1'b0);
    tbl[2]  = mk(1'b1, 8'h03, 1'b0, 3'd3, 1'b1, 8'h01, 1'b0, 16'd0, 1'b0);
    tbl[3]  = mk(1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h02, 1'b0, 16'd0, 1'b0);
    tbl[4]  = mk(1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h03, 1'b0, 16'd0, 1'b0);
    tbl[5]  = mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b0);
    // Full and drop: six pushes into four slots, then drain.
    tbl[6]  = mk(1'b1, 8'hA0, 1'b0, 3'd1, 1'b1, 8'hA0, 1'b0, 16'd0, 1'b0);
    tbl[7]  = mk(1'b1, 8'hA1, 1'b0, 3'd2, 1'b1, 8'hA0, 1'b0, 16'd0, 1'b0);
    tbl[8]  = mk(1'b1, 8'hA2, 1'b0, 3'd3, 1'b1, 8'hA0, 1'b0, 16'd0, 1'b0);
    tbl[9]  = mk(1'b1, 8'hA3, 1'b0, 3'd4, 1'b1, 8'hA0, 1'b1, 16'd0, 1'b0);
    tbl[10] = mk(1'b1, 8'hA4, 1'b0, 3'd4, 1'b1, 8'hA0, 1'b1, 16'd1, 1'b1);
    tbl[11] = mk(1'b1, 8'hA5, 1'b0, 3'd4, 1'b1, 8'hA0, 1'b1, 16'd2, 1'b1);
    tbl[12] = mk(1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'hA1, 1'b0, 16'd2, 1'b1);
    tbl[13] = mk(1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'hA2, 1'b0, 16'd2, 1'b1);
    tbl[14] = mk(1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'hA3, 1'b0, 16'd2, 1'b1);
    tbl[15] = mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 16'd2, 1'b1);

    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;
    check("por.vld",   32'(out_vld),  32'd0);
    check("por.empty", 32'(empty),    32'd1);
    check("por.level", 32'(level),    32'd0);
    check("por.data",  32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      cycle(tbl[i].vld, tbl[i].data, tbl[i].rdy, 1'b0, t);
      check({t, ".t_level"}, 32'(level),    32'(tbl[i].e_level));
      check({t, ".t_vld"},   32'(out_vld),  32'(tbl[i].e_vld));
      check({t, ".t_full"},  32'(full),     32'(tbl[i].e_full));
      check({t, ".t_drop"},  32'(drop_cnt), 32'(tbl[i].e_drop));
      check({t, ".t_ovf"},   32'(overflow), 32'(tbl[i].e_ovf));
      if (tbl[i].e_vld) check({t, ".t_data"}, 32'(out_data), 32'(tbl[i].e_data));
    end

    // Full with simultaneous pop: push lands, nothing dropped, last out is 0xB4.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, "fpop.fill");
    check("fpop.full", 32'(full), 32'd1);
    cycle(1'b1, 8'hB4, 1'b1, 1'b0, "fpop.push");
    check("fpop.level", 32'(level),    32'd4);
    check("fpop.drop",  32'(drop_cnt), 32'd2);
    for (int i = 1; i <= 4; i++) begin
      check("fpop.order", 32'(out_data), 32'(8'hB0 + i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "fpop.drain");
    end
    check("fpop.empty", 32'(empty), 32'd1);

    // Wrap-around at level 1: ten push/pop pairs carrying 0..9.
    cycle(1'b1, 8'd0, 1'b0, 1'b0, "wrap.prime");
    for (int i = 0; i < 10; i++) begin
      check("wrap.order", 32'(out_data), 32'(i));
      cycle(i < 9, 8'(i + 1), 1'b1, 1'b0, "wrap.step");
      check("wrap.level", 32'(level), (i < 9) ? 32'd1 : 32'd0);
    end
    check("wrap.drop", 32'(drop_cnt), 32'd2);

    // Counter clear racing a drop.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr.pre");
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "clr.fill");
    check("clr.cnt3", 32'(drop_cnt), 32'd3);
    cycle(1'b1, 8'hCE, 1'b0, 1'b1, "clr.race");
    check("clr.drop0", 32'(drop_cnt), 32'd0);
    check("clr.ovf0",  32'(overflow), 32'd0);
    cycle(1'b1, 8'hCF, 1'b0, 1'b0, "clr.next");
    check("clr.drop1", 32'(drop_cnt), 32'd1);
    check("clr.ovf1",  32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "clr.drain");

    // Asynchronous reset mid-stream with three entries held.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, "rst.fill");
    check("rst.level3", 32'(level), 32'd3);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.vld",   32'(out_vld),  32'd0);
    check("rst.data",  32'(out_data), 32'd0);
    check("rst.level", 32'(level),    32'd0);
    check("rst.full",  32'(full),     32'd0);
    check("rst.empty", 32'(empty),    32'd1);
    check("rst.drop",  32'(drop_cnt), 32'd0);
    check("rst.ovf",   32'(overflow), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h11, 1'b0, 1'b0, "rst.first");
    check("rst.first_data", 32'(out_data), 32'h11);
    check("rst.first_vld",  32'(out_vld),  32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0, "rand");
    end

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
